// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: icache port, hazard-unit controls, next-PC select and IF/ID payload.
interface fetch_stage_if;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        pc_en;
    logic        pipe1_en;
    logic        flushed1;
    logic [1:0]  pc_src;
    logic        branch_sel;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        fetch_halted;

    modport master (
        input  ihit, iload, pc_en, pipe1_en, flushed1, pc_src, branch_sel,
               branch_target, jump_target, jr_target,
        output iREN, iaddr, pc, ifid_instr, ifid_npc, ifid_valid, fetch_halted
    );

    modport slave (
        output ihit, iload, pc_en, pipe1_en, flushed1, pc_src, branch_sel,
               branch_target, jump_target, jr_target,
        input  iREN, iaddr, pc, ifid_instr, ifid_npc, ifid_valid, fetch_halted
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, pending-redirect holding register, IF/ID register and HALT sequencing.
module fetch_stage #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_stage_if.master bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              pend_v_q, pend_v_d;
    logic [XLEN-1:0]   pend_tgt_q, pend_tgt_d;
    logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0]   ifid_npc_q, ifid_npc_d;
    logic              ifid_valid_q, ifid_valid_d;

    logic              redirect;
    logic [XLEN-1:0]   redir_tgt;
    logic [XLEN-1:0]   pc_plus4;
    logic              pc_upd;
    logic              fetch_load;

    assign pc_plus4 = pc_q + XLEN'(4);

    // Resolve the live redirect and its destination.
    always_comb begin
        redirect  = 1'b0;
        redir_tgt = pc_plus4;
        case (bus.pc_src)
            2'd1: begin
                redirect  = bus.branch_sel;
                redir_tgt = bus.branch_target;
            end
            2'd2: begin
                redirect  = 1'b1;
                redir_tgt = bus.jump_target;
            end
            2'd3: begin
                redirect  = 1'b1;
                redir_tgt = bus.jr_target;
            end
            default: begin
                redirect  = 1'b0;
                redir_tgt = pc_plus4;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_v_d     = pend_v_q;
        pend_tgt_d   = pend_tgt_q;
        ifid_instr_d = ifid_instr_q;
        ifid_npc_d   = ifid_npc_q;
        ifid_valid_d = ifid_valid_q;
        pc_upd       = 1'b0;
        fetch_load   = 1'b0;

        // PC frozen once halted; while HALT is pending only redirects may move it.
        if (state_q != HALTED) begin
            if (bus.pc_en) begin
                if (redirect) begin
                    pc_d   = redir_tgt;
                    pc_upd = 1'b1;
                end else if (pend_v_q) begin
                    pc_d   = pend_tgt_q;
                    pc_upd = 1'b1;
                end else if (state_q == RUN) begin
                    pc_d   = pc_plus4;
                    pc_upd = 1'b1;
                end
                if (pc_upd) begin
                    pend_v_d = 1'b0;
                end
            end else if (redirect && !pend_v_q) begin
                pend_v_d   = 1'b1;
                pend_tgt_d = redir_tgt;
            end
        end

        if (bus.pipe1_en) begin
            ifid_instr_d = '0;
            ifid_npc_d   = '0;
            ifid_valid_d = 1'b0;
            if (!bus.flushed1 && bus.ihit && state_q == RUN) begin
                ifid_instr_d = bus.iload;
                ifid_npc_d   = pc_plus4;
                ifid_valid_d = 1'b1;
                fetch_load   = 1'b1;
            end
        end

        case (state_q)
            RUN: begin
                if (fetch_load && bus.iload == HALT_WORD) begin
                    state_d = HALT_PEND;
                end
            end
            HALT_PEND: begin
                if (bus.pipe1_en) begin
                    state_d = bus.flushed1 ? RUN : HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= RUN;
            pc_q         <= PC_INIT;
            pend_v_q     <= 1'b0;
            pend_tgt_q   <= '0;
            ifid_instr_q <= '0;
            ifid_npc_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_v_q     <= pend_v_d;
            pend_tgt_q   <= pend_tgt_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_npc_q   <= ifid_npc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.iaddr        = pc_q;
    assign bus.iREN         = (state_q == RUN);
    assign bus.fetch_halted = (state_q != RUN);
    assign bus.ifid_instr   = ifid_instr_q;
    assign bus.ifid_npc     = ifid_npc_q;
    assign bus.ifid_valid   = ifid_valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;
    localparam logic [31:0] PC_INIT   = 32'h0000_0100;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   vectors    = 0;
    int   miscompares = 0;

    fetch_stage_if bus ();

    fetch_stage #(.PC_INIT(PC_INIT), .HALT_WORD(HALT_WORD)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pc, m_pend_tgt, m_instr, m_npc;
    logic        m_pend_v, m_valid, m_halt_pend, m_halted;

    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        logic        moved;
        logic        loaded;
        logic        running;
        if (!nrst) begin
            m_pc = PC_INIT; m_pend_v = 0; m_pend_tgt = 0;
            m_instr = 0; m_npc = 0; m_valid = 0;
            m_halt_pend = 0; m_halted = 0;
            return;
        end
        redir = (bus.pc_src == 2'd2) || (bus.pc_src == 2'd3) ||
                (bus.pc_src == 2'd1 && bus.branch_sel);
        tgt = (bus.pc_src == 2'd1) ? bus.branch_target :
              (bus.pc_src == 2'd2) ? bus.jump_target : bus.jr_target;
        running = !m_halt_pend && !m_halted;
        loaded  = bus.pipe1_en && !bus.flushed1 && bus.ihit && running;
        if (bus.pipe1_en) begin
            m_instr = loaded ? bus.iload : 32'h0;
            m_npc   = loaded ? m_pc + 32'd4 : 32'h0;
            m_valid = loaded;
        end
        if (!m_halted) begin
            if (bus.pc_en) begin
                moved = 1;
                if (redir)          m_pc = tgt;
                else if (m_pend_v)  m_pc = m_pend_tgt;
                else if (running)   m_pc = m_pc + 32'd4;
                else                moved = 0;
                if (moved) m_pend_v = 0;
            end else if (redir && !m_pend_v) begin
                m_pend_v = 1; m_pend_tgt = tgt;
            end
        end
        if (running) begin
            if (loaded && bus.iload == HALT_WORD) m_halt_pend = 1;
        end else if (m_halt_pend && bus.pipe1_en) begin
            m_halt_pend = 0;
            m_halted    = !bus.flushed1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("pc",           bus.pc,                  m_pc);
        check("iaddr",        bus.iaddr,               m_pc);
        check("iREN",         32'(bus.iREN),           32'(!(m_halt_pend || m_halted)));
        check("fetch_halted", 32'(bus.fetch_halted),   32'(m_halt_pend || m_halted));
        check("ifid_instr",   bus.ifid_instr,          m_instr);
        check("ifid_npc",     bus.ifid_npc,            m_npc);
        check("ifid_valid",   32'(bus.ifid_valid),     32'(m_valid));
    endtask

    // Model update is computed from the inputs held across the edge, then outputs compared.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();
        bus.ihit = 0; bus.iload = 0; bus.pc_en = 0; bus.pipe1_en = 0;
        bus.flushed1 = 0; bus.pc_src = 0; bus.branch_sel = 0;
        bus.branch_target = 0; bus.jump_target = 0; bus.jr_target = 0;
    endtask

    initial begin
        logic [31:0] held_pc;
        idle();
        m_pc = 0; m_pend_tgt = 0; m_instr = 0; m_npc = 0;
        m_pend_v = 0; m_valid = 0; m_halt_pend = 0; m_halted = 0;

        // Reset
        nrst = 0;
        #2;
        tick();
        check("reset_pc", bus.pc, 32'h100);
        check("reset_iren", 32'(bus.iREN), 32'd1);
        nrst = 1;

        // Sequential fetch
        bus.pc_en = 1; bus.pipe1_en = 1; bus.ihit = 1; bus.iload = 32'h2001_0005;
        tick();
        check("seq_iaddr1", bus.iaddr, 32'h104);
        check("seq_npc1", bus.ifid_npc, 32'h104);
        check("seq_valid1", 32'(bus.ifid_valid), 32'd1);
        tick();
        check("seq_iaddr2", bus.iaddr, 32'h108);

        // Jump with flush
        bus.pc_src = 2; bus.jump_target = 32'h400; bus.flushed1 = 1;
        tick();
        check("jump_iaddr", bus.iaddr, 32'h400);
        check("jump_bubble", 32'(bus.ifid_valid), 32'd0);

        // Stalled JR, second redirect ignored, then release
        bus.flushed1 = 0; bus.pc_en = 0; bus.pc_src = 3; bus.jr_target = 32'h80;
        tick();
        check("stall_hold", bus.pc, 32'h400);
        bus.jr_target = 32'h200;
        tick();
        check("stall_hold2", bus.pc, 32'h400);
        bus.pc_src = 0; bus.pc_en = 1;
        tick();
        check("stall_release", bus.pc, 32'h80);

        // HALT fetched, then advanced past IF/ID
        bus.iload = HALT_WORD;
        tick();
        check("halt_pend_iren", 32'(bus.iREN), 32'd0);
        check("halt_pend_flag", 32'(bus.fetch_halted), 32'd1);
        bus.iload = 32'h1111_2222;
        tick();
        held_pc = m_pc;
        for (int i = 0; i < 10; i++) begin
            bus.pc_src = 2'($urandom_range(0, 3)); bus.branch_sel = 1'($urandom());
            bus.jump_target = 32'h700; bus.jr_target = 32'h900; bus.branch_target = 32'h500;
            tick();
            check("halted_pc_frozen", bus.pc, 32'h84);
        end

        // Reset, HALT, then squash with taken branch
        bus.pc_src = 0; nrst = 0;
        tick();
        nrst = 1; bus.iload = HALT_WORD;
        tick();
        check("halt2_flag", 32'(bus.fetch_halted), 32'd1);
        bus.flushed1 = 1; bus.pc_src = 1; bus.branch_sel = 1; bus.branch_target = 32'h40;
        tick();
        check("squash_iren", 32'(bus.iREN), 32'd1);
        check("squash_iaddr", bus.iaddr, 32'h40);

        // Wrap past the top of the address space
        bus.pc_src = 2; bus.jump_target = 32'hFFFF_FFFC;
        tick();
        bus.pc_src = 0; bus.flushed1 = 0; bus.iload = 32'h0000_1234;
        tick();
        check("wrap_iaddr", bus.iaddr, 32'h0);
        check("wrap_npc", bus.ifid_npc, 32'h0);

        // Reset in the middle of HALT_PEND
        bus.iload = HALT_WORD;
        tick();
        nrst = 0; bus.pc_src = 2; bus.jump_target = 32'h3000;
        tick();
        check("rst_mid_pc", bus.pc, 32'h100);
        check("rst_mid_halted", 32'(bus.fetch_halted), 32'd0);
        nrst = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            nrst              = ($urandom_range(0, 63) != 0);
            bus.ihit          = 1'($urandom());
            bus.iload         = ($urandom_range(0, 7) == 0) ? HALT_WORD : $urandom();
            bus.pc_en         = ($urandom_range(0, 3) != 0);
            bus.pipe1_en      = ($urandom_range(0, 3) != 0);
            bus.flushed1      = ($urandom_range(0, 4) == 0);
            bus.pc_src        = 2'($urandom_range(0, 3));
            bus.branch_sel    = 1'($urandom());
            bus.branch_target = $urandom() & 32'hFFFF_FFFC;
            bus.jump_target   = $urandom() & 32'hFFFF_FFFC;
            bus.jr_target     = $urandom() & 32'hFFFF_FFFC;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage diaosi pipeline: owns the program counter, the icache request, and the IF/ID pipeline register. Consumes the hazard unit's `pc_en`, `pipe1_en` and `flushed1` plus the resolved next-PC selection from decode/execute. Produces the instruction/next-PC pair consumed by decode. Stops fetching cleanly on HALT.

## Interface
Parameters:
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding treated as HALT.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `ihit`  in  1  icache returns a valid `iload` this cycle.
- `iload`  in  32  instruction word from icache.
- `iREN`  out  1  icache read enable.
- `iaddr`  out  32  icache address; always equal to `pc`.
- `pc_en`  in  1  PC update enable from the hazard unit.
- `pipe1_en`  in  1  IF/ID register enable from the hazard unit.
- `flushed1`  in  1  replace the IF/ID input with a bubble.
- `pc_src`  in  2  next-PC select: 0 = PC+4, 1 = BRANCH, 2 = JUMP, 3 = JR.
- `branch_sel`  in  1  branch taken; only meaningful when `pc_src` = 1.
- `branch_target`  in  32  branch destination.
- `jump_target`  in  32  J/JAL destination.
- `jr_target`  in  32  JR register value.
- `pc`  out  32  current PC.
- `ifid_instr`  out  32  latched instruction.
- `ifid_npc`  out  32  latched PC+4.
- `ifid_valid`  out  1  latched entry is a real instruction.
- `fetch_halted`  out  1  high in HALT_PEND or HALTED.

## Operation
- Redirect condition: `pc_src` = 2, or `pc_src` = 3, or (`pc_src` = 1 and `branch_sel`). The target is the matching `*_target` input.
- Pending redirect register (`pend_v`, `pend_tgt`):
  - If a redirect is present while `pc_en` = 0 and `pend_v` = 0, capture it.
  - If `pend_v` = 1 already, a new redirect is ignored (first one held).
- PC update happens only when `pc_en` = 1. Priority for the next PC:
  1. Live redirect target.
  2. `pend_tgt` if `pend_v`.
  3. PC+4, computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Any PC update clears `pend_v`.
- IF/ID register updates only when `pipe1_en` = 1:
  - If `flushed1`: instr = 0, npc = 0, valid = 0.
  - Else if `ihit` and state is RUN: instr = `iload`, npc = `pc`+4, valid = 1.
  - Otherwise: bubble (0, 0, 0).
- FSM states: RUN, HALT_PEND, HALTED.
  - RUN → HALT_PEND: IF/ID loads a valid word equal to `HALT_WORD`.
  - HALT_PEND → RUN: `pipe1_en` and `flushed1` both high (HALT squashed). The accompanying redirect or `pend_tgt` updates the PC as normal.
  - HALT_PEND → HALTED: `pipe1_en` high and `flushed1` low. HALT has advanced past IF/ID, and IF/ID loads a bubble.
  - HALTED: terminal until reset. The PC is frozen even if `pc_en` = 1, and redirects are ignored.
- `iREN` = 1 only in RUN.
- In HALT_PEND the PC advances only on a redirect or pending redirect; a PC+4 update is suppressed.

## Timing
- Reset values, applied on the first rising edge with `nRST` = 0:
  - `pc` = `PC_INIT`, state = RUN, `pend_v` = 0.
  - `ifid_instr` = 0, `ifid_npc` = 0, `ifid_valid` = 0.
  - `fetch_halted` = 0, `iREN` = 1.
- Reset mid-operation discards pending redirects and HALT state in the same cycle.
- `iREN`, `iaddr` and `fetch_halted` are purely derived from registered state, with no combinational path from inputs.
- Redirect latency: a redirect asserted with `pc_en` = 1 in cycle N appears on `iaddr` in cycle N+1.
- A redirect captured while stalled takes effect one cycle after `pc_en` next rises.
- `pipe1_en` = 1 together with `flushed1` = 1 takes priority over `ihit`.
- `pc_en` and `pipe1_en` are independent. The PC may hold while IF/ID advances (load-use stall); in that case IF/ID loads whatever the rules above select.

## Test plan
- Reset with `PC_INIT` = 32'h100, then `pc_en` = `pipe1_en` = `ihit` = 1 for three cycles with `iload` = 32'h2001_0005 → `iaddr` goes 0x100, 0x104, 0x108; `ifid_npc` = 0x104 after the first edge, with `ifid_valid` = 1.
- JUMP: `pc_src` = 2, `jump_target` = 0x400, `flushed1` = 1 at PC 0x108 → next `iaddr` = 0x400; IF/ID holds a bubble (valid 0, instr 0).
- Stalled redirect: `pc_en` = 0 with `pc_src` = 3, `jr_target` = 0x80 for one cycle, then `pc_src` = 0 and `pc_en` = 1 → PC holds, then becomes 0x80; a second redirect to 0x200 during the stall is ignored.
- HALT: `iload` = 32'hFFFF_FFFF with `ihit` → HALT_PEND, `iREN` = 0, `fetch_halted` = 1. Next `pipe1_en` without flush → HALTED, after which PC stays constant for 10 cycles with `pc_en` = 1.
- HALT squash: in HALT_PEND, apply `pipe1_en` = `flushed1` = 1 with a taken BRANCH to 0x40 → state RUN, `iREN` = 1, `iaddr` = 0x40.
- Wrap and reset: PC at 32'hFFFF_FFFC plus an `ihit` cycle → `iaddr` = 0. Asserting `nRST` = 0 mid-HALT_PEND → all outputs return to their reset values on the next edge.
